// File: rtl/clock60_down.sv
// MM:SS BCD countdown timer (59:59 max) with set/run/pause/done control.
// Decrements once per 1 Hz enable; bo pulses for one cycle on reaching 00:00.
module clock60_down (
    input  logic       clks,
    input  logic       sclr,
    input  logic       tick,
    input  logic       sset,
    input  logic       sinc,
    input  logic       selw,
    input  logic       start,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic       bo,
    output logic       flag,
    output logic       run
);

    typedef enum logic [2:0] {StIdle, StSet, StRun, StPause, StDone} state_e;

    state_e     r_state, w_state_d;
    logic [3:0] r_s0, r_s1, r_m0, r_m1;
    logic [3:0] w_s0_d, w_s1_d, w_m0_d, w_m1_d;
    logic       r_bo, r_flag, r_run;
    logic       w_bo_d, w_flag_d;
    logic [7:0] w_sec_inc, w_min_inc, w_sec_dec, w_min_dec;
    logic       w_zero, w_one, w_sec_zero;

    // Packed result is {tens, ones}; both wrap within 00..59.
    function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            if (tens == 4'd5) return 8'h00;
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

    function automatic logic [7:0] dec60(input logic [3:0] tens, input logic [3:0] ones);
        if (ones != 4'd0) return {tens, ones - 4'd1};
        if (tens != 4'd0) return {tens - 4'd1, 4'd9};
        return 8'h59;
    endfunction

    assign w_sec_inc  = inc60(r_s1, r_s0);
    assign w_min_inc  = inc60(r_m1, r_m0);
    assign w_sec_dec  = dec60(r_s1, r_s0);
    assign w_min_dec  = dec60(r_m1, r_m0);
    assign w_sec_zero = (r_s1 == 4'd0) && (r_s0 == 4'd0);
    assign w_zero     = w_sec_zero && (r_m1 == 4'd0) && (r_m0 == 4'd0);
    assign w_one      = (r_m1 == 4'd0) && (r_m0 == 4'd0) && (r_s1 == 4'd0) && (r_s0 == 4'd1);

    always_comb begin
        w_state_d = r_state;
        w_s0_d    = r_s0;
        w_s1_d    = r_s1;
        w_m0_d    = r_m0;
        w_m1_d    = r_m1;
        w_bo_d    = 1'b0;

        if (sset) begin
            w_state_d = StSet;
            if (r_state == StSet && sinc) begin
                if (selw) {w_m1_d, w_m0_d} = w_min_inc;
                else      {w_s1_d, w_s0_d} = w_sec_inc;
            end
        end else begin
            unique case (r_state)
                StSet:   w_state_d = StIdle;
                StIdle:  if (start && !w_zero) w_state_d = StRun;
                StRun: begin
                    // Start has priority: a tick coinciding with pause is dropped.
                    if (start) begin
                        w_state_d = StPause;
                    end else if (tick) begin
                        {w_s1_d, w_s0_d} = w_sec_dec;
                        if (w_sec_zero) {w_m1_d, w_m0_d} = w_min_dec;
                        if (w_one) begin
                            w_state_d = StDone;
                            w_bo_d    = 1'b1;
                        end
                    end
                end
                StPause: if (start) w_state_d = StRun;
                StDone:  if (start) w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end

        w_flag_d = (w_state_d == StRun) && (w_m1_d == 4'd0) && (w_m0_d == 4'd0) &&
                   (((w_s1_d == 4'd0) && (w_s0_d != 4'd0)) ||
                    ((w_s1_d == 4'd1) && (w_s0_d == 4'd0)));
    end

    always_ff @(posedge clks) begin
        if (!sclr) begin
            r_state <= StIdle;
            r_s0    <= 4'd0;
            r_s1    <= 4'd0;
            r_m0    <= 4'd0;
            r_m1    <= 4'd0;
            r_bo    <= 1'b0;
            r_flag  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_s0    <= w_s0_d;
            r_s1    <= w_s1_d;
            r_m0    <= w_m0_d;
            r_m1    <= w_m1_d;
            r_bo    <= w_bo_d;
            r_flag  <= w_flag_d;
            r_run   <= (w_state_d == StRun);
        end
    end

    assign s0   = r_s0;
    assign s1   = r_s1;
    assign m0   = r_m0;
    assign m1   = r_m1;
    assign bo   = r_bo;
    assign flag = r_flag;
    assign run  = r_run;

endmodule

// File: tb/tb_clock60_down.sv
// Scoreboard bench for clock60_down: each driven cycle queues its expected
// display/bo/flag/run, which is popped and compared after the clock edge.
module tb_clock60_down;

    logic       clks = 1'b0;
    logic       sclr = 1'b0;
    logic       tick = 1'b0;
    logic       sset = 1'b0;
    logic       sinc = 1'b0;
    logic       selw = 1'b0;
    logic       start = 1'b0;
    logic [3:0] s0, s1, m0, m1;
    logic       bo, flag, run;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
        logic        bo;
        logic        flag;
        logic        run;
    } exp_t;

    exp_t sb_q[$];

    always #5 clks = ~clks;

    clock60_down dut (
        .clks  (clks),
        .sclr  (sclr),
        .tick  (tick),
        .sset  (sset),
        .sinc  (sinc),
        .selw  (selw),
        .start (start),
        .s0    (s0),
        .s1    (s1),
        .m0    (m0),
        .m1    (m1),
        .bo    (bo),
        .flag  (flag),
        .run   (run)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd(input int m, input int s);
        logic [15:0] v;
        v = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected response, compare after the edge.
    task automatic cyc(input string tag, input logic rst_n, input logic ss, input logic si,
                       input logic sw, input logic st, input logic tk, input logic [15:0] ev,
                       input logic eb, input logic ef, input logic er);
        exp_t e;
        sclr  = rst_n;
        sset  = ss;
        sinc  = si;
        selw  = sw;
        start = st;
        tick  = tk;
        e.tag  = tag;
        e.val  = ev;
        e.bo   = eb;
        e.flag = ef;
        e.run  = er;
        sb_q.push_back(e);
        @(posedge clks);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".val"}, {m1, m0, s1, s0}, e.val);
        check({e.tag, ".bo"}, {15'd0, bo}, {15'd0, e.bo});
        check({e.tag, ".flag"}, {15'd0, flag}, {15'd0, e.flag});
        check({e.tag, ".run"}, {15'd0, run}, {15'd0, e.run});
    endtask

    task automatic preset(input int m, input int s);
        cyc("rst", 1'b0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc("set_enter", 1'b1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        for (int i = 1; i <= m; i++) cyc("set_min", 1'b1, 1, 1, 1, 0, 0, bcd(i, 0), 0, 0, 0);
        for (int i = 1; i <= s; i++) cyc("set_sec", 1'b1, 1, 1, 0, 0, 0, bcd(m, i), 0, 0, 0);
        cyc("set_exit", 1'b1, 0, 0, 0, 0, 0, bcd(m, s), 0, 0, 0);
    endtask

    initial begin
        // Set path to 03:05, idle ignores tick
        preset(3, 5);
        cyc("idle_hold", 1, 0, 0, 0, 0, 0, bcd(3, 5), 0, 0, 0);
        cyc("idle_tick", 1, 0, 0, 0, 0, 1, bcd(3, 5), 0, 0, 0);

        // Minute borrow 01:00 -> 00:59
        preset(1, 0);
        cyc("mb_start", 1, 0, 0, 0, 1, 0, bcd(1, 0), 0, 0, 1);
        cyc("mb_tick", 1, 0, 0, 0, 0, 1, bcd(0, 59), 0, 0, 1);

        // 10:00 -> 09:59
        preset(10, 0);
        cyc("tm_start", 1, 0, 0, 0, 1, 0, bcd(10, 0), 0, 0, 1);
        cyc("tm_tick", 1, 0, 0, 0, 0, 1, bcd(9, 59), 0, 0, 1);

        // Expiry from 00:11
        preset(0, 11);
        cyc("exp_start", 1, 0, 0, 0, 1, 0, bcd(0, 11), 0, 0, 1);
        for (int i = 10; i >= 0; i--)
            cyc("exp_tick", 1, 0, 0, 0, 0, 1, bcd(0, i), i == 0, (i >= 1 && i <= 10), i != 0);
        cyc("done_hold", 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
        cyc("done_tick", 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
        cyc("done_start", 1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        cyc("idle_zero_start", 1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);

        // Pause collisions
        preset(0, 31);
        cyc("p_start", 1, 0, 0, 0, 1, 0, bcd(0, 31), 0, 0, 1);
        cyc("p_tick", 1, 0, 0, 0, 0, 1, bcd(0, 30), 0, 0, 1);
        cyc("p_coll", 1, 0, 0, 0, 1, 1, bcd(0, 30), 0, 0, 0);
        cyc("p_tick1", 1, 0, 0, 0, 0, 1, bcd(0, 30), 0, 0, 0);
        cyc("p_tick2", 1, 0, 0, 0, 0, 1, bcd(0, 30), 0, 0, 0);
        cyc("p_resume", 1, 0, 0, 0, 1, 0, bcd(0, 30), 0, 0, 1);
        cyc("p_dec", 1, 0, 0, 0, 0, 1, bcd(0, 29), 0, 0, 1);
        cyc("p_pause2", 1, 0, 0, 0, 1, 0, bcd(0, 29), 0, 0, 0);
        cyc("p_res_tick", 1, 0, 0, 0, 1, 1, bcd(0, 29), 0, 0, 1);
        cyc("p_dec2", 1, 0, 0, 0, 0, 1, bcd(0, 28), 0, 0, 1);

        // Start+tick in IDLE, flag on entry, flag cleared in PAUSE
        preset(0, 3);
        cyc("i_start_tick", 1, 0, 0, 0, 1, 1, bcd(0, 3), 0, 1, 1);
        cyc("i_dec", 1, 0, 0, 0, 0, 1, bcd(0, 2), 0, 1, 1);
        cyc("i_pause", 1, 0, 0, 0, 1, 0, bcd(0, 2), 0, 0, 0);

        // Maximum value, set override, set wraps
        preset(59, 59);
        cyc("max_start", 1, 0, 0, 0, 1, 0, bcd(59, 59), 0, 0, 1);
        cyc("max_tick", 1, 0, 0, 0, 0, 1, bcd(59, 58), 0, 0, 1);
        cyc("set_over", 1, 1, 0, 0, 1, 0, bcd(59, 58), 0, 0, 0);
        cyc("set_inc_tick", 1, 1, 1, 0, 0, 1, bcd(59, 59), 0, 0, 0);
        cyc("sec_wrap", 1, 1, 1, 0, 0, 0, bcd(59, 0), 0, 0, 0);
        cyc("min_wrap", 1, 1, 1, 1, 0, 0, bcd(0, 0), 0, 0, 0);

        // Reset mid-run at 12:34
        preset(12, 34);
        cyc("r_start", 1, 0, 0, 0, 1, 0, bcd(12, 34), 0, 0, 1);
        cyc("r_tick", 1, 0, 0, 0, 0, 1, bcd(12, 33), 0, 0, 1);
        cyc("r_mid", 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
        cyc("r_start0", 1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
        cyc("r_tick0", 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
